// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared FSM type and command-decode constants for the SPI register bank.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    RD_TURN = 2'd2
  } state_t;

  // Command flag positions, counted down from the word MSB.
  localparam int RW_BIT    = 0;
  localparam int BURST_BIT = 1;

  localparam logic [15:0] BAD_READ      = 16'hDEAD;
  localparam int          ERR_CNT_WIDTH = 8;

endpackage

// File: rtl/spi_reg_bank_sync_2ff.sv
// sync_2ff: single-bit two-flop synchronizer with a configurable reset level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: word-level read/write command interpreter behind a 16-bit SPI slave.
// Define SPI_REG_BURST_EN to enable auto-incrementing burst reads and writes.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    ADDR_WIDTH   = 6,
  parameter int                    NUM_CTRL     = 8,
  parameter int                    NUM_STAT     = 8,
  parameter logic [DATA_WIDTH-1:0] IDLE_PATTERN = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ss,
  input  logic                           done,
  input  logic [DATA_WIDTH-1:0]          rx_word,
  output logic [DATA_WIDTH-1:0]          tx_word,
  input  logic [NUM_STAT*DATA_WIDTH-1:0] stat_in,
  output logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_out,
  output logic                           wr_stb,
  output logic [ADDR_WIDTH-1:0]          wr_addr,
  output logic [ERR_CNT_WIDTH-1:0]       err_cnt
);

  localparam int RW_POS = DATA_WIDTH - 1 - RW_BIT;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    burst_q;
  logic [DATA_WIDTH-1:0]   ctrl [NUM_CTRL];
  logic                    ss_sync, ss_d, ss_rise;
  logic [ADDR_WIDTH-1:0]   cmd_addr, rd_addr;
  logic                    cmd_rd, cmd_burst, wr_ok, rd_bad, err_hit;
  logic [DATA_WIDTH-1:0]   rd_data;

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  sync_2ff #(.RESET_VAL(1'b1)) u_ss_sync (
    .clk (clk),
    .rst (rst),
    .d   (ss),
    .q   (ss_sync)
  );

  always_ff @(posedge clk) begin
    if (rst) ss_d <= 1'b1;
    else     ss_d <= ss_sync;
  end

  assign ss_rise  = ss_sync & ~ss_d;
  assign cmd_addr = rx_word[ADDR_WIDTH-1:0];
  assign cmd_rd   = rx_word[RW_POS];
`ifdef SPI_REG_BURST_EN
  localparam int BURST_POS = DATA_WIDTH - 1 - BURST_BIT;
  assign cmd_burst = rx_word[BURST_POS];
`else
  assign cmd_burst = 1'b0;
`endif

  // A burst read in RD_TURN fetches the register after the one last returned.
  always_comb begin
    rd_addr = (state == RD_TURN) ? addr_q + 1'b1 : cmd_addr;
    rd_data = DATA_WIDTH'(BAD_READ);
    rd_bad  = 1'b1;
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (int'(rd_addr) == i) begin
        rd_data = ctrl[i];
        rd_bad  = 1'b0;
      end
    end
    for (int j = 0; j < NUM_STAT; j++) begin
      if (int'(rd_addr) == NUM_CTRL + j) begin
        rd_data = stat_in[j*DATA_WIDTH +: DATA_WIDTH];
        rd_bad  = 1'b0;
      end
    end
  end

  assign wr_ok = int'(addr_q) < NUM_CTRL;

  always_comb begin
    err_hit = 1'b0;
    if (done) begin
      case (state)
        IDLE:    err_hit = cmd_rd && rd_bad;
        WR_DATA: err_hit = !wr_ok;
        RD_TURN: err_hit = burst_q && rd_bad;
        default: err_hit = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      burst_q <= 1'b0;
      tx_word <= IDLE_PATTERN;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      err_cnt <= '0;
      for (int i = 0; i < NUM_CTRL; i++) ctrl[i] <= '0;
    end else begin
      wr_stb <= 1'b0;
      if (err_hit) err_cnt <= sat_inc(err_cnt);
      if (done) begin
        case (state)
          IDLE: begin
            addr_q  <= cmd_addr;
            burst_q <= cmd_burst;
            if (cmd_rd) begin
              tx_word <= rd_data;
              state   <= RD_TURN;
            end else begin
              state   <= WR_DATA;
            end
          end
          WR_DATA: begin
            if (wr_ok) begin
              for (int i = 0; i < NUM_CTRL; i++)
                if (int'(addr_q) == i) ctrl[i] <= rx_word;
              wr_stb  <= 1'b1;
              wr_addr <= addr_q;
            end
            if (burst_q) addr_q <= addr_q + 1'b1;
            else         state  <= IDLE;
          end
          RD_TURN: begin
            if (burst_q) begin
              tx_word <= rd_data;
              addr_q  <= addr_q + 1'b1;
            end else begin
              tx_word <= IDLE_PATTERN;
              state   <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
      // Frame abort overrides the next state; a coincident word is still fully processed.
      if (ss_rise) begin
        state <= IDLE;
        if (state == RD_TURN && !done) tx_word <= IDLE_PATTERN;
      end
    end
  end

  for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl
    assign ctrl_out[g*DATA_WIDTH +: DATA_WIDTH] = ctrl[g];
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: randomized and directed checks of spi_reg_bank against a word-level model.
module tb_spi_reg_bank;

  localparam int DW = 16;
  localparam int AW = 6;
  localparam int NC = 8;
  localparam int NS = 8;
  localparam logic [DW-1:0] IDLE_PAT = 16'h0000;

  logic              clk = 1'b0;
  logic              rst, ss, done;
  logic [DW-1:0]     rx_word, tx_word;
  logic [NS*DW-1:0]  stat_in;
  logic [NC*DW-1:0]  ctrl_out;
  logic              wr_stb;
  logic [AW-1:0]     wr_addr;
  logic [7:0]        err_cnt;

  int errors = 0;
  int checks = 0;

  // Word-level reference: what each register holds and what the next word means.
  logic [DW-1:0] ctrl_m [NC];
  logic [DW-1:0] stat_m [NS];
  int            err_m;
  logic [DW-1:0] tx_m;
  int            pend_wr;
  bit            pend_turn;
  int            stb_m = 0;
  int            stb_seen = 0;

  spi_reg_bank #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CTRL(NC), .NUM_STAT(NS), .IDLE_PATTERN(IDLE_PAT)
  ) dut (
    .clk(clk), .rst(rst), .ss(ss), .done(done), .rx_word(rx_word), .tx_word(tx_word),
    .stat_in(stat_in), .ctrl_out(ctrl_out), .wr_stb(wr_stb), .wr_addr(wr_addr), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_stb === 1'b1) stb_seen++;

  function automatic logic [NC*DW-1:0] ctrl_pack();
    logic [NC*DW-1:0] v;
    for (int i = 0; i < NC; i++) v[i*DW +: DW] = ctrl_m[i];
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NC; i++) ctrl_m[i] = '0;
    err_m = 0; tx_m = IDLE_PAT; pend_wr = -1; pend_turn = 1'b0;
  endfunction

  function automatic void model_err();
    if (err_m < 255) err_m++;
  endfunction

  function automatic void model_word(input logic [DW-1:0] w);
    int a;
    a = int'(w[AW-1:0]);
    if (pend_wr >= 0) begin
      if (pend_wr < NC) begin ctrl_m[pend_wr] = w; stb_m++; end
      else model_err();
      pend_wr = -1;
    end else if (pend_turn) begin
      tx_m = IDLE_PAT; pend_turn = 1'b0;
    end else if (w[DW-1]) begin
      if (a < NC)           tx_m = ctrl_m[a];
      else if (a < NC + NS) tx_m = stat_m[a-NC];
      else begin tx_m = 16'hDEAD; model_err(); end
      pend_turn = 1'b1;
    end else begin
      pend_wr = a;
    end
  endfunction

  function automatic void model_abort();
    if (pend_turn) tx_m = IDLE_PAT;
    pend_turn = 1'b0; pend_wr = -1;
  endfunction

  task automatic set_stat(input int idx, input logic [DW-1:0] v);
    stat_m[idx] = v;
    stat_in[idx*DW +: DW] = v;
  endtask

  task automatic drive_word(input logic [DW-1:0] w);
    @(negedge clk); done = 1'b1; rx_word = w;
    @(negedge clk); done = 1'b0; rx_word = 16'($urandom);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] w);
    drive_word(w);
    model_word(w);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic do_abort();
    @(negedge clk); ss = 1'b1;
    repeat (4) @(negedge clk);
    ss = 1'b0;
    repeat (3) @(negedge clk);
    model_abort();
    #1;
  endtask

  // ss rises two edges before done so the synchronized edge lands on the done cycle.
  task automatic send_with_abort(input logic [DW-1:0] w);
    @(negedge clk); ss = 1'b1;
    @(negedge clk);
    @(negedge clk); done = 1'b1; rx_word = w;
    @(negedge clk); done = 1'b0;
    model_word(w);
    pend_wr = -1; pend_turn = 1'b0;
    #1;
  endtask

  task automatic release_ss();
    @(negedge clk); ss = 1'b0;
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; repeat (3) @(negedge clk); rst = 1'b0; model_reset(); #1;
    checks++; if (tx_word !== IDLE_PAT) begin errors++; $display("FAIL reset_tx: got %h want %h", tx_word, IDLE_PAT); end
    checks++; if (ctrl_out !== '0) begin errors++; $display("FAIL reset_ctrl: got %h want 0", ctrl_out); end
    checks++; if (wr_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b want 0", wr_stb); end
    checks++; if (wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr: got %h want 0", wr_addr); end
    checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL reset_err: got %h want 00", err_cnt); end
    send(16'h0003);
    do_reset();
    send(16'h0007);
    send(16'hAAAA);
    checks++; if (ctrl_out[3*DW +: DW] !== 16'h0000) begin errors++; $display("FAIL midreset_ctrl3: got %h want 0000", ctrl_out[3*DW +: DW]); end
    checks++; if (ctrl_out[7*DW +: DW] !== 16'hAAAA) begin errors++; $display("FAIL midreset_ctrl7: got %h want aaaa", ctrl_out[7*DW +: DW]); end
  endtask

  task automatic test_write();
    int base;
    do_reset();
    base = stb_seen;
    send(16'h0003);
    send(16'h1234);
    checks++; if (wr_stb !== 1'b1) begin errors++; $display("FAIL write_stb: got %b want 1", wr_stb); end
    checks++; if (wr_addr !== 6'd3) begin errors++; $display("FAIL write_addr: got %0d want 3", wr_addr); end
    checks++; if (ctrl_out[3*DW +: DW] !== 16'h1234) begin errors++; $display("FAIL write_ctrl3: got %h want 1234", ctrl_out[3*DW +: DW]); end
    checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL write_err: got %h want 00", err_cnt); end
    @(negedge clk); #1;
    checks++; if (stb_seen - base !== 1) begin errors++; $display("FAIL write_pulses: got %0d want 1", stb_seen - base); end
  endtask

  task automatic test_read_status();
    set_stat(1, 16'hBEEF);
    send(16'h8009);
    checks++; if (tx_word !== 16'hBEEF) begin errors++; $display("FAIL read_stat: got %h want beef", tx_word); end
    send(16'h0000);
    checks++; if (tx_word !== IDLE_PAT) begin errors++; $display("FAIL read_turn: got %h want %h", tx_word, IDLE_PAT); end
    send(16'h8003);
    checks++; if (tx_word !== 16'h1234) begin errors++; $display("FAIL read_ctrl: got %h want 1234", tx_word); end
    send(16'h0000);
  endtask

  task automatic test_bad_access();
    do_reset();
    send(16'h000A);
    send(16'h5A5A);
    checks++; if (ctrl_out !== '0) begin errors++; $display("FAIL bad_wr_ctrl: got %h want 0", ctrl_out); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL bad_wr_err: got %0d want 1", err_cnt); end
    send(16'h8028);
    checks++; if (tx_word !== 16'hDEAD) begin errors++; $display("FAIL bad_rd_tx: got %h want dead", tx_word); end
    checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL bad_rd_err: got %0d want 2", err_cnt); end
    send(16'h0000);
    for (int k = 0; k < 300; k++) begin
      send(16'h8028);
      send(16'h0000);
    end
    checks++; if (err_cnt !== 8'hFF) begin errors++; $display("FAIL bad_saturate: got %h want ff", err_cnt); end
  endtask

  task automatic test_abort();
    int base;
    do_reset();
    base = stb_seen;
    send(16'h0002);
    do_abort();
    send(16'h5555);
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL abort_cmd_err: got %0d want 0", err_cnt); end
    send(16'h7777);
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL abort_wrdata_err: got %0d want 1", err_cnt); end
    checks++; if (ctrl_out !== '0) begin errors++; $display("FAIL abort_ctrl: got %h want 0", ctrl_out); end
    checks++; if (stb_seen !== base) begin errors++; $display("FAIL abort_pulses: got %0d want 0", stb_seen - base); end
    send(16'h0001);
    send(16'h1357);
    send(16'h8001);
    checks++; if (tx_word !== 16'h1357) begin errors++; $display("FAIL abort_rd_tx: got %h want 1357", tx_word); end
    do_abort();
    checks++; if (tx_word !== IDLE_PAT) begin errors++; $display("FAIL abort_turn_idle: got %h want %h", tx_word, IDLE_PAT); end
    send(16'h8001);
    checks++; if (tx_word !== 16'h1357) begin errors++; $display("FAIL abort_reread: got %h want 1357", tx_word); end
    send(16'h0000);
  endtask

  task automatic test_simultaneous();
    send(16'h0004);
    send_with_abort(16'hCAFE);
    checks++; if (ctrl_out[4*DW +: DW] !== 16'hCAFE) begin errors++; $display("FAIL simul_ctrl4: got %h want cafe", ctrl_out[4*DW +: DW]); end
    checks++; if (wr_stb !== 1'b1 || wr_addr !== 6'd4) begin errors++; $display("FAIL simul_stb: got %b/%0d want 1/4", wr_stb, wr_addr); end
    release_ss();
    send_with_abort(16'h0005);
    release_ss();
    send(16'h8004);
    checks++; if (tx_word !== 16'hCAFE) begin errors++; $display("FAIL simul_idle_after: got %h want cafe", tx_word); end
    checks++; if (ctrl_out[5*DW +: DW] !== 16'h0000) begin errors++; $display("FAIL simul_ctrl5: got %h want 0000", ctrl_out[5*DW +: DW]); end
    send(16'h0000);
  endtask

  task automatic test_burst();
    int base;
    do_reset();
    base = stb_seen;
`ifdef SPI_REG_BURST_EN
    drive_word(16'h4000);
    drive_word(16'h0001);
    drive_word(16'h0002);
    drive_word(16'h0003);
    checks++; if (ctrl_out[3*DW-1:0] !== 48'h0003_0002_0001) begin errors++; $display("FAIL burst_wr: got %h want 000300020001", ctrl_out[3*DW-1:0]); end
    checks++; if (stb_seen - base !== 3) begin errors++; $display("FAIL burst_pulses: got %0d want 3", stb_seen - base); end
    do_abort();
    drive_word(16'hC000);
    checks++; if (tx_word !== 16'h0001) begin errors++; $display("FAIL burst_rd0: got %h want 0001", tx_word); end
    drive_word(16'h0000);
    checks++; if (tx_word !== 16'h0002) begin errors++; $display("FAIL burst_rd1: got %h want 0002", tx_word); end
    drive_word(16'h0000);
    checks++; if (tx_word !== 16'h0003) begin errors++; $display("FAIL burst_rd2: got %h want 0003", tx_word); end
    do_abort();
    checks++; if (tx_word !== IDLE_PAT) begin errors++; $display("FAIL burst_rd_end: got %h want %h", tx_word, IDLE_PAT); end
    set_stat(7, 16'h7E57);
    drive_word(16'hC00F);
    checks++; if (tx_word !== 16'h7E57) begin errors++; $display("FAIL burst_rd_stat: got %h want 7e57", tx_word); end
    drive_word(16'h0000);
    checks++; if (tx_word !== 16'hDEAD || err_cnt !== 8'd1) begin errors++; $display("FAIL burst_rd_oob: got %h/%0d want dead/1", tx_word, err_cnt); end
    do_abort();
    do_reset();
`else
    send(16'h4000);
    send(16'h0001);
    send(16'h0002);
    send(16'h0003);
    checks++; if (ctrl_out[3*DW-1:0] !== 48'h0003_0000_0001) begin errors++; $display("FAIL noburst_wr: got %h want 000300000001", ctrl_out[3*DW-1:0]); end
    checks++; if (stb_seen - base !== 2) begin errors++; $display("FAIL noburst_pulses: got %0d want 2", stb_seen - base); end
`endif
  endtask

  task automatic test_random();
    logic [DW-1:0] w;
    do_reset();
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        do_abort();
      end else begin
        for (int j = 0; j < NS; j++) set_stat(j, 16'($urandom));
        w = 16'($urandom);
        if (pend_wr < 0 && !pend_turn) begin
          w[AW-1:0] = 6'($urandom_range(0, 19));
`ifdef SPI_REG_BURST_EN
          w[DW-2] = 1'b0;
`endif
        end
        send(w);
      end
      checks++; if (tx_word !== tx_m) begin errors++; $display("FAIL rand_tx[%0d]: got %h want %h", n, tx_word, tx_m); end
      checks++; if (ctrl_out !== ctrl_pack()) begin errors++; $display("FAIL rand_ctrl[%0d]: got %h want %h", n, ctrl_out, ctrl_pack()); end
      checks++; if (err_cnt !== 8'(err_m)) begin errors++; $display("FAIL rand_err[%0d]: got %0d want %0d", n, err_cnt, err_m); end
      checks++; if (stb_seen !== stb_m) begin errors++; $display("FAIL rand_pulses[%0d]: got %0d want %0d", n, stb_seen, stb_m); end
    end
  endtask

  initial begin
    rst = 1'b1; ss = 1'b0; done = 1'b0; rx_word = '0; stat_in = '0;
    for (int j = 0; j < NS; j++) stat_m[j] = '0;
    model_reset();
    test_reset();
    test_write();
    test_read_status();
    test_bad_access();
    test_abort();
    test_simultaneous();
    test_burst();
    stb_m = stb_seen;
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
- Word-level command interpreter directly downstream of the 16-bit SPI slave.
- Consumes each received word (rx_word qualified by the one-cycle done pulse) and decodes read/write commands against a bank of control registers (R/W) and status registers (read-only).
- Drives tx_word back into the slave's din so read data is shifted out to the SPI master.
- Control registers fan out to the acquisition datapath; status registers are sampled from it.

Parameters:
- DATA_WIDTH, 16, SPI word width; must match the slave.
- ADDR_WIDTH, 6, command address field width, rx_word[ADDR_WIDTH-1:0].
- NUM_CTRL, 8, R/W control registers at addresses 0..NUM_CTRL-1.
- NUM_STAT, 8, read-only status registers at addresses NUM_CTRL..NUM_CTRL+NUM_STAT-1.
- IDLE_PATTERN, 16'h0000, tx_word value when no read is pending.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ss  in  1  raw SPI slave select, active-low, asynchronous; used only for frame abort.
- done  in  1  one-cycle pulse from the slave: rx_word is valid.
- rx_word  in  DATA_WIDTH  received word (slave dout).
- tx_word  out  DATA_WIDTH  word to transmit (slave din).
- stat_in  in  NUM_STAT*DATA_WIDTH  packed status words; index 0 in the LSBs.
- ctrl_out  out  NUM_CTRL*DATA_WIDTH  packed control registers.
- wr_stb  out  1  one-cycle pulse when a control register is written.
- wr_addr  out  ADDR_WIDTH  address of the last write; valid while wr_stb is high.
- err_cnt  out  8  saturating count of bad accesses.

Behaviour:
- Reset values: ctrl_out=0, tx_word=IDLE_PATTERN, wr_stb=0, wr_addr=0, err_cnt=0, state=IDLE, ss synchronizer=1.
- Command word format:
  - bit DATA_WIDTH-1: 1=read, 0=write.
  - bits [ADDR_WIDTH-1:0]: address.
  - remaining bits ignored.
- ss passes through a 2-flop synchronizer; ss_rise is the 0->1 edge of the synchronized signal.
- States IDLE, WR_DATA, RD_TURN. All actions below occur only on the cycle where done=1.
- IDLE, write command:
  - Latch address; go to WR_DATA.
- IDLE, read command:
  - Valid address: tx_word <= register (ctrl value, or stat_in sampled this cycle), registered one cycle after done.
  - Invalid address (>= NUM_CTRL+NUM_STAT): tx_word <= 16'hDEAD and err_cnt increments.
  - Go to RD_TURN.
- WR_DATA:
  - Address < NUM_CTRL: ctrl[addr] <= rx_word; wr_stb=1 and wr_addr=addr, one cycle after done.
  - Status or out-of-range address: no write, no wr_stb, err_cnt increments.
  - Go to IDLE.
- RD_TURN:
  - The received turnaround word is ignored.
  - tx_word <= IDLE_PATTERN; go to IDLE.
- Read timing consequence: the slave captures din at each word end, so read data appears in the word after the turnaround word. That word may itself carry the next command. A read is therefore CMD + TURN, and the data returns during the third word.
- err_cnt saturates at 8'hFF.
- Abort (ss_rise):
  - State forced to IDLE; a pending write address is discarded.
  - If the state was RD_TURN, tx_word <= IDLE_PATTERN.
- done and ss_rise in the same cycle: the done action completes fully (write commits, tx_word load kept), then the state is forced to IDLE.
- rst mid-transaction: everything returns to reset values on the next clock edge.

Optional Feature:
- Macro: SPI_REG_BURST_EN.
- With the macro defined, command bit DATA_WIDTH-2 is a burst flag.
- Write burst:
  - The FSM stays in WR_DATA; each done writes addr and then increments addr (modulo 2^ADDR_WIDTH).
  - Ends on ss_rise.
- Read burst:
  - The FSM stays in RD_TURN; each done loads tx_word with reg[addr+1] and advances addr.
  - Out-of-range addresses give 16'hDEAD and increment err_cnt.
  - Ends on ss_rise, which sets tx_word <= IDLE_PATTERN.
- Without the macro, the burst bit is ignored and all transfers are single.

Decomposition:
- Package spi_reg_pkg contains:
  - the state enum (IDLE, WR_DATA, RD_TURN);
  - RW_BIT and BURST_BIT positions;
  - BAD_READ=16'hDEAD;
  - ERR_CNT_WIDTH=8.
- One sub-module: sync_2ff, the single-bit 2-flop synchronizer for ss.

Test Plan:
- Write: done with rx_word=16'h0003, then done with 16'h1234 -> ctrl[3]=16'h1234; wr_stb pulses once with wr_addr=3; err_cnt=0.
- Read status: stat_in[addr 9]=16'hBEEF; done with 16'h8009 -> tx_word=16'hBEEF one cycle later; after the next done, tx_word=IDLE_PATTERN.
- Bad accesses: write to 10 (status register) and read of 40 -> no ctrl change, tx_word=16'hDEAD for the read, err_cnt=2. Force 300 bad accesses -> err_cnt=8'hFF.
- Abort: write command to address 2, then ss 0->1 before the data word, then done with 16'h5555 -> treated as a command (write to address 0x15, FSM goes to WR_DATA); ctrl[2] unchanged.
- Simultaneous: done with write data coincident with ss_rise -> write commits; state is IDLE afterwards.
- With SPI_REG_BURST_EN: command 16'h4000 followed by data 1, 2, 3 -> ctrl[0..2]=1,2,3 and three wr_stb pulses.
